// File: rtl/musa_fetch_pkg.sv
// musa_fetch_pkg: shared constants and types for the MUSA fetch stage
// Holds the next-PC select encodings, the fetch FSM state type and the word size.
package musa_fetch_pkg;
    localparam logic [2:0] PC_SRC_SEQ = 3'd0;
    localparam logic [2:0] PC_SRC_BR  = 3'd1;
    localparam logic [2:0] PC_SRC_J   = 3'd2;
    localparam logic [2:0] PC_SRC_JR  = 3'd3;
    localparam logic [2:0] PC_SRC_RET = 3'd4;
    localparam int WORD_BYTES = 4;
    typedef enum logic {FETCH, WAIT} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode controls, instruction-memory handshake and decode-facing outputs
// master: the fetch stage (drives imem_req/imem_addr and the decode outputs)
// slave : the surrounding core (drives decode controls and memory responses)
interface fetch_stage_if;
    logic [2:0]  pc_src;
    logic        pc_write;
    logic [31:0] jump_jpc;
    logic [31:0] imm_ext;
    logic        branch_taken;
    logic [31:0] reg_target;
    logic        push;
    logic        pop;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        stack_ovf;
    logic        stack_unf;
    modport master (
        input  pc_src, pc_write, jump_jpc, imm_ext, branch_taken, reg_target, push, pop,
        input  imem_rdata, imem_valid,
        output imem_req, imem_addr, instruction, instr_valid, pc_plus4, stack_ovf, stack_unf
    );
    modport slave (
        output pc_src, pc_write, jump_jpc, imm_ext, branch_taken, reg_target, push, pop,
        output imem_rdata, imem_valid,
        input  imem_req, imem_addr, instruction, instr_valid, pc_plus4, stack_ovf, stack_unf
    );
endinterface

// File: rtl/return_stack.sv
// return_stack: circular return-address stack with sticky overflow/underflow flags
// Ports: clk, rst (async active-low), push/pop/en (operation applies only when en=1),
//        wdata (address to push), top (newest entry), empty, full, ovf, unf (sticky).
module return_stack #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        en,
    input  logic [31:0] wdata,
    output logic [31:0] top,
    output logic        empty,
    output logic        full,
    output logic        ovf,
    output logic        unf
);
    localparam int PW = $clog2(STACK_DEPTH);
    logic [31:0]   r_mem [STACK_DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_cnt;
    logic          r_ovf;
    logic          r_unf;
    logic [PW-1:0] w_ptr_m1;
    logic [PW-1:0] w_widx;
    logic          w_wr;
    logic          w_rep;
    logic          w_dec;
    // r_ptr is the next free slot; the newest entry lives one below it
    assign w_ptr_m1 = r_ptr - PW'(1);
    assign top      = r_mem[w_ptr_m1];
    assign empty    = (r_cnt == '0);
    assign full     = (r_cnt == (PW+1)'(STACK_DEPTH));
    assign ovf      = r_ovf;
    assign unf      = r_unf;
    // push+pop on an empty stack degrades to a plain push
    assign w_wr   = en && push && (!pop || empty);
    assign w_rep  = en && push && pop && !empty;
    assign w_dec  = en && pop && !push && !empty;
    assign w_widx = w_rep ? w_ptr_m1 : r_ptr;
    always_ff @(posedge clk) begin
        if (w_wr || w_rep)
            r_mem[w_widx] <= wdata;
    end
    // a push when full overwrites the oldest slot, which is exactly r_ptr after wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ptr <= w_wr ? r_ptr + PW'(1) : w_dec ? w_ptr_m1 : r_ptr;
            r_cnt <= (w_wr && !full) ? r_cnt + (PW+1)'(1) : w_dec ? r_cnt - (PW+1)'(1) : r_cnt;
            r_ovf <= r_ovf || (en && push && !pop && full);
            r_unf <= r_unf || (en && pop && empty);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MUSA instruction fetch - PC, imem request, decode register, return stack
// Ports: clk, rst (async active-low), bus (fetch_stage_if.master: decode controls,
//        imem handshake, instruction/instr_valid/pc_plus4, sticky stack flags).
// Build option MUSA_FETCH_ALIGN_CHECK_EN: misaligned targets redirect to RESET_PC and
// set the sticky 'misaligned' output; without it targets are silently aligned down.
module fetch_stage
    import musa_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          STACK_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
`ifdef MUSA_FETCH_ALIGN_CHECK_EN
    ,
    output logic          misaligned
`endif
);
    fetch_state_e r_state;
    fetch_state_e w_state_nx;
    logic         r_armed;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic [31:0]  w_pc4;
    logic [31:0]  w_raw;
    logic [31:0]  w_next;
    logic [31:0]  w_top;
    logic         w_empty;
    logic         w_unused_full;
    logic         w_en;
    logic         w_take;
    assign w_pc4  = r_pc + 32'(WORD_BYTES);
    assign w_en   = (r_state == WAIT) && bus.pc_write;
    // r_armed holds off the request for one cycle after reset release,
    // so a stale response from before reset can never be captured
    assign w_take = (r_state == FETCH) && r_armed && bus.imem_valid;
    return_stack #(.STACK_DEPTH(STACK_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.push),
        .pop   (bus.pop),
        .en    (w_en),
        .wdata (w_pc4),
        .top   (w_top),
        .empty (w_empty),
        .full  (w_unused_full),
        .ovf   (bus.stack_ovf),
        .unf   (bus.stack_unf)
    );
    always_comb begin
        w_state_nx = r_state;
        w_state_nx = w_take ? WAIT : w_en ? FETCH : r_state;
    end
    always_comb begin
        w_raw = w_pc4;
        case (bus.pc_src)
            PC_SRC_BR:  w_raw = bus.branch_taken ? w_pc4 + (bus.imm_ext << 2) : w_pc4;
            PC_SRC_J:   w_raw = (w_pc4 & 32'hF000_0000) | (bus.jump_jpc & 32'h0FFF_FFFF);
            PC_SRC_JR:  w_raw = bus.reg_target;
            PC_SRC_RET: w_raw = w_empty ? RESET_PC : w_top;
            default:    w_raw = w_pc4;
        endcase
    end
`ifdef MUSA_FETCH_ALIGN_CHECK_EN
    logic w_mis;
    assign w_mis  = |w_raw[1:0];
    assign w_next = w_mis ? RESET_PC : w_raw;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            misaligned <= 1'b0;
        else if (w_en && w_mis)
            misaligned <= 1'b1;
    end
`else
    assign w_next = w_raw & ~32'd3;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= FETCH;
        else
            r_state <= w_state_nx;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_take) begin
                r_instr <= bus.imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_en) begin
                r_pc    <= w_next;
                r_valid <= 1'b0;
            end
        end
    end
    assign bus.imem_req    = (r_state == FETCH) && r_armed;
    assign bus.imem_addr   = r_pc;
    assign bus.instruction = r_instr;
    assign bus.instr_valid = r_valid;
    assign bus.pc_plus4    = w_pc4;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MUSA core: owns the program counter, requests words from instruction memory and presents each instruction to the decode stage.
- Consumes the decode stage's next-PC controls (pc_src, pc_write, jump_jpc, push, pop) and the sign-extended immediate.
- Contains a return-address stack that serves call (push) and return (pop) instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- STACK_DEPTH, 8, number of return-address stack entries (power of two, at least 2).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- pc_src  input  3  next-PC select from decode.
- pc_write  input  1  advance/redirect strobe from decode.
- jump_jpc  input  32  jump field already shifted left by 2.
- imm_ext  input  32  sign-extended 16-bit immediate (branch offset, in words).
- branch_taken  input  1  branch condition result from the ALU.
- reg_target  input  32  register value for a register jump.
- push  input  1  push PC+4 onto the return stack (call).
- pop  input  1  pop the return stack (return).
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  instruction memory word address (byte address).
- imem_rdata  input  32  instruction memory read data.
- imem_valid  input  1  imem_rdata valid; one-cycle pulse.
- instruction  output  32  registered instruction presented to decode.
- instr_valid  output  1  instruction holds a fetched word.
- pc_plus4  output  32  PC+4 of the presented instruction.
- stack_ovf  output  1  sticky: a push occurred while the stack was full.
- stack_unf  output  1  sticky: a pop occurred while the stack was empty.

Behaviour:
Reset values (asynchronous, while rst=0):
- pc=RESET_PC, state=FETCH, instruction=0, instr_valid=0, imem_req=0.
- Stack count=0, stack pointer=0, stack_ovf=0, stack_unf=0.
- pc_plus4 follows pc+4 combinationally.

Reset mid-transaction:
- Any outstanding memory request is abandoned.
- An imem_valid arriving in the first cycle after reset release is ignored.
- After release, the first request is issued in the next cycle.

FSM states:
- FETCH: imem_req=1, imem_addr=pc. On imem_valid: instruction<=imem_rdata, instr_valid<=1, go to WAIT. pc_write is ignored in FETCH.
- WAIT: imem_req=0; instruction and instr_valid are held. On pc_write=1: pc<=next_pc, stack operation applied, instr_valid<=0, go to FETCH. Fetch-to-decode latency is one cycle after imem_valid.

next_pc by pc_src:
- 0: pc+4.
- 1: if branch_taken, pc+4+(imm_ext<<2); otherwise pc+4.
- 2: {pc_plus4[31:28], jump_jpc[27:0]}.
- 3: reg_target.
- 4: top of the return stack.
- 5 to 7: pc+4 (reserved).

Arithmetic and stack rules:
- All PC arithmetic is 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Stack operations take effect only on a cycle with WAIT and pc_write=1.
- push: write pc+4 at the pointer, then advance the pointer. When count=STACK_DEPTH, the oldest entry is overwritten, count stays at STACK_DEPTH and stack_ovf<=1.
- pop: next_pc=top entry, pointer decrements, count decrements. When count=0, next_pc=RESET_PC, pointer and count are unchanged and stack_unf<=1.
- push and pop together: next_pc=top entry, and the top entry is replaced by pc+4. Pointer and count are unchanged. When count=0, next_pc=RESET_PC, stack_unf<=1, and the entry is pushed (count becomes 1).
- pop without pc_src=4: the entry is discarded and next_pc follows pc_src.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MUSA_FETCH_ALIGN_CHECK_EN.
- Defined: a next_pc with bits [1:0]≠0 is replaced by RESET_PC. An extra output port, misaligned (1 bit, sticky, reset 0), is set to 1.
- Undefined: no misaligned port. next_pc[1:0] is forced to 2'b00, so the target is silently aligned down.

Decomposition:
- Package musa_fetch_pkg: PC_SRC_SEQ=0, PC_SRC_BR=1, PC_SRC_J=2, PC_SRC_JR=3, PC_SRC_RET=4; fetch state encoding (FETCH, WAIT); WORD_BYTES=4.
- Sub-module return_stack: parameter STACK_DEPTH. Ports clk, rst, push, pop, en, wdata, top, empty, full, ovf, unf. It is instantiated once.

Test Plan:
- Reset release with RESET_PC=0, imem_valid returned 2 cycles after each req → imem_addr sequence 0,4,8 with pc_src=0; instr_valid rises one cycle after each imem_valid.
- Branch: pc=0x100, pc_src=1, imm_ext=32'hFFFFFFFE, branch_taken=1 → next imem_addr=0xFC; with branch_taken=0 → 0x104.
- Jump: pc=0xA0000010, jump_jpc=0x00000400, pc_src=2 → imem_addr=0xA0000400.
- Call/return: push at pc=0x200 with pc_src=2 to 0x800; later pop with pc_src=4 → imem_addr=0x204; then a second pop → imem_addr=RESET_PC and stack_unf=1.
- Overflow: 9 pushes with STACK_DEPTH=8 → stack_ovf=1; 8 pops return the 8 most recent PC+4 values, newest first.
- Reset asserted while waiting for imem_valid, with a late imem_valid after release → the late data is ignored, and the first address after release is RESET_PC with instr_valid=0 until a new imem_valid.
